// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_pkg
//  Description : Shared definitions for the external-strobe UART transmitter:
//                default frame parameters and the FSM state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    // Default frame configuration
    localparam int unsigned c_N_DEFAULT            = 8;
    localparam int unsigned c_CLKS_PER_BIT_DEFAULT = 434;
    localparam int unsigned c_PARITY_EN_DEFAULT    = 0;

    // Transmitter state encoding
    localparam int unsigned c_STATE_W = 3;
    localparam logic [c_STATE_W-1:0] c_ST_IDLE   = 3'd0;
    localparam logic [c_STATE_W-1:0] c_ST_START  = 3'd1;
    localparam logic [c_STATE_W-1:0] c_ST_DATA   = 3'd2;
    localparam logic [c_STATE_W-1:0] c_ST_PARITY = 3'd3;
    localparam logic [c_STATE_W-1:0] c_ST_STOP   = 3'd4;

    typedef enum logic [c_STATE_W-1:0] {
        ST_IDLE   = c_ST_IDLE,
        ST_START  = c_ST_START,
        ST_DATA   = c_ST_DATA,
        ST_PARITY = c_ST_PARITY,
        ST_STOP   = c_ST_STOP
    } uart_state_e;

    // Number of serial bits in one frame: start + data + optional parity + stop
    function automatic int unsigned f_frame_bits(input int unsigned n_bits,
                                                 input int unsigned parity_en);
        return n_bits + 2 + ((parity_en != 0) ? 1 : 0);
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_baud_cnt.sv
`default_nettype none
// ============================================================================
//  Module      : uart_baud_cnt
//  Description : Bit-period counter. Counts clk cycles within one serial bit
//                and strobes o_bit_done on the last cycle of the bit. The
//                transmitter restarts it when a frame is accepted so the
//                start bit is timed from the acceptance edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_baud_cnt
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = c_CLKS_PER_BIT_DEFAULT
) (
    input  logic clk,
    input  logic reset_n,
    input  logic i_restart,
    input  logic i_enable,
    output logic o_bit_done
);

    localparam int unsigned           c_CNT_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [c_CNT_W-1:0]    c_CNT_LAST = c_CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [c_CNT_W-1:0]    c_CNT_ONE  = c_CNT_W'(1);

    logic [c_CNT_W-1:0] r_cnt_q;

    // Cycle counter: cleared on restart, wraps at every bit boundary while enabled
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt_q <= '0;
        end else if (i_restart) begin
            r_cnt_q <= '0;
        end else if (i_enable) begin
            if (r_cnt_q == c_CNT_LAST) begin
                r_cnt_q <= '0;
            end else begin
                r_cnt_q <= r_cnt_q + c_CNT_ONE;
            end
        end
    end

    // A restart request always wins over a pending bit boundary
    assign o_bit_done = i_enable && !i_restart && (r_cnt_q == c_CNT_LAST);

endmodule
`default_nettype wire

// File: rtl/uart_tx_ext.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx_ext
//  Description : UART transmitter started by a one-cycle strobe from a bus
//                slave. Sends start bit, N data bits LSB first, an optional
//                even-parity bit and a stop bit. All outputs are registered;
//                uart_busy covers the whole frame and end_tx pulses for one
//                cycle on return to idle, in which a new strobe is accepted.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_ext
    import uart_pkg::*;
#(
    parameter int unsigned N            = c_N_DEFAULT,
    parameter int unsigned CLKS_PER_BIT = c_CLKS_PER_BIT_DEFAULT,
    parameter int unsigned PARITY_EN    = c_PARITY_EN_DEFAULT
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         tx_external,
    input  logic [N-1:0] to_uart,
    output logic         tx,
    output logic         uart_busy,
    output logic         end_tx
);

    localparam int unsigned        c_IDX_W    = $clog2(N) + 1;
    localparam logic [c_IDX_W-1:0] c_IDX_LAST = c_IDX_W'(N - 1);
    localparam logic [c_IDX_W-1:0] c_IDX_ONE  = c_IDX_W'(1);
    localparam bit                 c_HAS_PAR  = (PARITY_EN != 0);

    uart_state_e          r_state_q;
    logic [N-1:0]         r_shift_q;
    logic [c_IDX_W-1:0]   r_idx_q;
    logic                 r_parity_q;
    logic                 r_tx_q;
    logic                 r_busy_q;
    logic                 r_end_tx_q;

    logic                 w_accept;
    logic                 w_bit_done;
    logic [N-1:0]         w_shift_next;

    // Strobes are only honoured in IDLE; anything arriving mid-frame is dropped
    assign w_accept     = (r_state_q == ST_IDLE) && tx_external;
    assign w_shift_next = r_shift_q >> 1;

    uart_baud_cnt #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud_cnt (
        .clk        (clk),
        .reset_n    (reset_n),
        .i_restart  (w_accept),
        .i_enable   (r_busy_q),
        .o_bit_done (w_bit_done)
    );

    // Frame sequencer with registered serial line, busy and completion pulse
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state_q  <= ST_IDLE;
            r_shift_q  <= '0;
            r_idx_q    <= '0;
            r_parity_q <= 1'b0;
            r_tx_q     <= 1'b1;
            r_busy_q   <= 1'b0;
            r_end_tx_q <= 1'b0;
        end else begin
            r_end_tx_q <= 1'b0;
            case (r_state_q)
                ST_IDLE: begin
                    r_tx_q <= 1'b1;
                    if (tx_external) begin
                        r_shift_q  <= to_uart;
                        r_parity_q <= ^to_uart;
                        r_idx_q    <= '0;
                        r_tx_q     <= 1'b0;
                        r_busy_q   <= 1'b1;
                        r_state_q  <= ST_START;
                    end
                end

                ST_START: begin
                    if (w_bit_done) begin
                        r_tx_q    <= r_shift_q[0];
                        r_state_q <= ST_DATA;
                    end
                end

                ST_DATA: begin
                    if (w_bit_done) begin
                        r_shift_q <= w_shift_next;
                        if (r_idx_q == c_IDX_LAST) begin
                            r_idx_q <= '0;
                            if (c_HAS_PAR) begin
                                r_tx_q    <= r_parity_q;
                                r_state_q <= ST_PARITY;
                            end else begin
                                r_tx_q    <= 1'b1;
                                r_state_q <= ST_STOP;
                            end
                        end else begin
                            r_idx_q <= r_idx_q + c_IDX_ONE;
                            r_tx_q  <= w_shift_next[0];
                        end
                    end
                end

                ST_PARITY: begin
                    if (w_bit_done) begin
                        r_tx_q    <= 1'b1;
                        r_state_q <= ST_STOP;
                    end
                end

                ST_STOP: begin
                    if (w_bit_done) begin
                        r_tx_q     <= 1'b1;
                        r_busy_q   <= 1'b0;
                        r_end_tx_q <= 1'b1;
                        r_state_q  <= ST_IDLE;
                    end
                end

                default: begin
                    r_tx_q    <= 1'b1;
                    r_busy_q  <= 1'b0;
                    r_state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign tx        = r_tx_q;
    assign uart_busy = r_busy_q;
    assign end_tx    = r_end_tx_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_ext.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_tx_ext
//  Description : Directed self-checking bench for uart_tx_ext (N=8,
//                CLKS_PER_BIT=4). One instance without parity, one with.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_ext;

    localparam int unsigned c_N   = 8;
    localparam int unsigned c_CPB = 4;

    logic       clk;
    logic       reset_n;
    logic       tx_ext0, tx_ext1;
    logic [7:0] data0, data1;
    logic       tx0, busy0, end0;
    logic       tx1, busy1, end1;

    int n_cmp;
    int n_err;

    uart_tx_ext #(.N(c_N), .CLKS_PER_BIT(c_CPB), .PARITY_EN(0)) dut0 (
        .clk        (clk),
        .reset_n    (reset_n),
        .tx_external(tx_ext0),
        .to_uart    (data0),
        .tx         (tx0),
        .uart_busy  (busy0),
        .end_tx     (end0)
    );

    uart_tx_ext #(.N(c_N), .CLKS_PER_BIT(c_CPB), .PARITY_EN(1)) dut1 (
        .clk        (clk),
        .reset_n    (reset_n),
        .tx_external(tx_ext1),
        .to_uart    (data1),
        .tx         (tx1),
        .uart_busy  (busy1),
        .end_tx     (end1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Advance to 1 time unit after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit p, input logic stb, input logic [7:0] d);
        if (p) begin
            tx_ext1 = stb;
            data1   = d;
        end else begin
            tx_ext0 = stb;
            data0   = d;
        end
    endtask

    // Send one frame from the current cycle; checks every cycle of the frame
    // and the end_tx cycle. ign_at > 0 injects an extra strobe of 0xFF that is
    // sampled at edge k+ign_at and must be ignored.
    task automatic frame(input bit p, input logic [7:0] d, input int ign_at);
        logic [10:0] bits;
        int          nbits;
        logic        o_tx, o_busy, o_end;
        bits  = '1;
        nbits = p ? 11 : 10;
        bits[0] = 1'b0;
        for (int i = 0; i < 8; i++) bits[i+1] = d[i];
        if (p) bits[9] = ^d;
        drive(p, 1'b1, d);
        tick();
        for (int c = 1; c <= nbits * 4; c++) begin
            if (c == ign_at) drive(p, 1'b1, 8'hFF);
            else             drive(p, 1'b0, 8'h00);
            o_tx   = p ? tx1   : tx0;
            o_busy = p ? busy1 : busy0;
            o_end  = p ? end1  : end0;
            chk($sformatf("tx d=%h c=%0d", d, c),     o_tx,   bits[(c-1)/4]);
            chk($sformatf("busy d=%h c=%0d", d, c),   o_busy, 1'b1);
            chk($sformatf("end_tx d=%h c=%0d", d, c), o_end,  1'b0);
            tick();
        end
        drive(p, 1'b0, 8'h00);
        o_tx   = p ? tx1   : tx0;
        o_busy = p ? busy1 : busy0;
        o_end  = p ? end1  : end0;
        chk($sformatf("end_tx pulse d=%h", d), o_end,  1'b1);
        chk($sformatf("busy drop d=%h", d),    o_busy, 1'b0);
        chk($sformatf("tx idle d=%h", d),      o_tx,   1'b1);
    endtask

    task automatic idle(input bit p, input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            chk("idle tx",     p ? tx1   : tx0,   1'b1);
            chk("idle busy",   p ? busy1 : busy0, 1'b0);
            chk("idle end_tx", p ? end1  : end0,  1'b0);
        end
    endtask

    initial begin
        n_cmp   = 0;
        n_err   = 0;
        reset_n = 1'b1;
        tx_ext0 = 1'b0;
        tx_ext1 = 1'b0;
        data0   = 8'h00;
        data1   = 8'h00;

        // Asynchronous reset state
        #1 reset_n = 1'b0;
        #1;
        chk("rst tx0",   tx0,   1'b1);
        chk("rst busy0", busy0, 1'b0);
        chk("rst end0",  end0,  1'b0);
        chk("rst tx1",   tx1,   1'b1);
        chk("rst busy1", busy1, 1'b0);
        chk("rst end1",  end1,  1'b0);
        repeat (3) tick();
        chk("rst hold tx0", tx0, 1'b1);
        reset_n = 1'b1;

        // First strobe on the first edge after release; 0xA5 without parity
        frame(0, 8'hA5, 0);
        idle(0, 3);

        // 0x07 with even parity (parity bit = 1)
        frame(1, 8'h07, 0);
        idle(1, 3);

        // 0x00 frame with a 0xFF strobe at k+10 that must be ignored
        frame(0, 8'h00, 10);
        idle(0, 2);

        // Back-to-back: second strobe in the end_tx cycle
        frame(0, 8'hC3, 0);
        frame(0, 8'h3C, 0);
        idle(0, 2);

        // Reset at k+20 aborts the frame
        drive(0, 1'b1, 8'hA5);
        tick();
        drive(0, 1'b0, 8'h00);
        for (int c = 1; c < 20; c++) tick();
        reset_n = 1'b0;
        #1;
        chk("abort tx",   tx0,   1'b1);
        chk("abort busy", busy0, 1'b0);
        chk("abort end",  end0,  1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("abort hold tx",  tx0,  1'b1);
            chk("abort hold end", end0, 1'b0);
        end
        reset_n = 1'b1;
        frame(0, 8'h5A, 0);
        idle(0, 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_tx_ext.md
UART_TX_EXT -- requirements
Module: uart_tx_ext

Interface
REQ-001 Parameter N, default 8: number of data bits per frame.
REQ-002 Parameter CLKS_PER_BIT, default 434: clk cycles per serial bit, minimum 2.
REQ-003 Parameter PARITY_EN, default 0: 1 inserts an even-parity bit after the data bits.
REQ-004 clk  input  1  single system clock; all state updates on its rising edge.
REQ-005 reset_n  input  1  reset, asynchronous and active-low.
REQ-006 tx_external  input  1  one-cycle start strobe from the bus-side slave.
REQ-007 to_uart  input  N  byte to transmit, valid in the cycle tx_external is high.
REQ-008 tx  output  1  serial line; idles high.
REQ-009 uart_busy  output  1  high from frame acceptance until frame end.
REQ-010 end_tx  output  1  one-cycle pulse marking frame completion.

Function
REQ-011 The FSM SHALL have states IDLE, START, DATA, PARITY, STOP, with encoding held in the shared package.
REQ-012 In IDLE with tx_external=1 at edge k, the block SHALL latch to_uart into a shift register, enter START, and drive uart_busy=1 and tx=0 from cycle k+1.
REQ-013 tx_external while uart_busy=1 SHALL be ignored; it does not change the frame in flight, the latched data, or the counters.
REQ-014 Each bit SHALL be held on tx for exactly CLKS_PER_BIT cycles, timed by a bit-cycle counter that restarts at every bit boundary.
REQ-015 Transition order:
- START to DATA.
- DATA to PARITY after N bits when PARITY_EN=1, otherwise DATA to STOP.
- PARITY to STOP.
- STOP to IDLE.
REQ-016 Data bits SHALL go LSB first, shifting the register right once per bit, with a bit index counter of width clog2(N)+1.
REQ-017 The parity bit SHALL equal the XOR of the N latched bits (even parity); the STOP bit SHALL be 1.
REQ-018 Frame length SHALL be (N+2+PARITY_EN)*CLKS_PER_BIT cycles of uart_busy=1.
REQ-019 At the last cycle of STOP, the next edge SHALL return the block to IDLE, drop uart_busy to 0 and raise end_tx to 1 for exactly that one cycle.
REQ-020 A tx_external arriving in that end_tx cycle SHALL be accepted (back-to-back frames), giving tx=0 on the following cycle.
REQ-021 All outputs SHALL be registered; there is no combinational path from inputs to outputs.

Reset
REQ-022 While reset_n=0, outputs SHALL be tx=1, uart_busy=0, end_tx=0, and the FSM SHALL be in IDLE with counters and shift register at 0.
REQ-023 Reset asserted mid-frame SHALL abort the frame immediately (tx=1, asynchronous) with no end_tx pulse.
REQ-024 The first accepted strobe SHALL be on the first rising edge after reset_n deasserts.

Structure
REQ-025 A package uart_pkg SHALL hold the state encoding localparams and the default N, CLKS_PER_BIT and PARITY_EN values.
REQ-026 One sub-module, uart_baud_cnt, SHALL provide the bit-cycle counter and a bit_done strobe, and SHALL restart on FSM request.

Verification (N=8, CLKS_PER_BIT=4, strobe at edge k)
REQ-027 PARITY_EN=0, to_uart=0xA5:
- tx over cycles k+1..k+40, 4 cycles per bit: 0,1,0,1,0,0,1,0,1,1.
- uart_busy high for k+1..k+40.
- end_tx=1 only at k+41.
REQ-028 PARITY_EN=1, to_uart=0x07: the parity bit is 1 at k+37..k+40, stop at k+41..k+44, and end_tx is at k+45.
REQ-029 tx_external pulsed at k+10 with to_uart=0xFF during an 0x00 frame: the frame is unchanged (all data bits 0) and exactly one end_tx occurs.
REQ-030 A second strobe in the end_tx cycle, to_uart=0x3C: tx=0 on the next cycle, and two complete frames are produced with no idle-high gap beyond the stop bit.
REQ-031 reset_n pulled low at k+20: tx=1, uart_busy=0 and no end_tx occur, and a new 0x5A frame after release is transmitted correctly.
